// File: rtl/rvee_mem.sv
// RVee memory stage: issues loads/stores over a single-outstanding request/response
// bus, aligns and extends load data, writes back, and flags misaligned accesses.
module rvee_mem #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_rd_we,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_mem_data,
    input  logic            ex_mem_load,
    input  logic            ex_mem_store,
    input  logic [1:0]      ex_mem_size,
    input  logic            ex_mem_sext,
    output logic            ex_done,
    output logic            ex_idle,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_ready,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exception,
    output logic [3:0]      exc_cause,
    output logic [XLEN-1:0] exc_addr,
    output logic [XLEN-1:0] exc_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic            w_is_mem;
    logic            w_misaligned;
    logic            w_idle_valid;
    logic            w_start;
    logic            w_alu;
    logic            w_accept;
    logic            w_resp;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load;

    logic            r_store;
    logic [1:0]      r_size;
    logic [1:0]      r_lane;
    logic            r_sext;
    logic [4:0]      r_rd;
    logic            r_rd_we;

    logic            r_bus_req;
    logic            r_bus_we;
    logic [XLEN-1:0] r_bus_addr;
    logic [XLEN-1:0] r_bus_wdata;
    logic [3:0]      r_bus_be;
    logic            r_wb_we;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    assign w_is_mem     = ex_mem_load | ex_mem_store;
    assign w_idle_valid = (r_state == S_IDLE) && ex_valid;
    assign w_start      = w_idle_valid && w_is_mem && !w_misaligned;
    assign w_alu        = w_idle_valid && !w_is_mem;
    assign w_accept     = (r_state == S_REQ) && bus_ready;
    assign w_resp       = (r_state == S_WAIT) && bus_rvalid;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = ex_mem_data;
        case (ex_mem_size)
            2'd0: begin
                w_be    = 4'b0001 << ex_result[1:0];
                w_wdata = {4{ex_mem_data[7:0]}};
            end
            2'd1: begin
                w_misaligned = ex_result[0];
                w_be         = 4'b0011 << ex_result[1:0];
                w_wdata      = {2{ex_mem_data[15:0]}};
            end
            2'd2:    w_misaligned = |ex_result[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    // Selected lane is shifted down to bit 0, then masked and extended by size.
    assign w_shifted = bus_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            2'd0:    w_load = {{(XLEN-8){r_sext & w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    w_load = {{(XLEN-16){r_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        w_next  = r_state;
        ex_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_REQ;
                if (w_alu || exception) ex_done = 1'b1;
            end
            S_REQ: begin
                if (bus_ready) begin
                    if (r_store) begin
                        ex_done = 1'b1;
                        w_next  = S_IDLE;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    ex_done = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign exception = w_idle_valid && w_is_mem && w_misaligned;
    assign exc_cause = exception ? (ex_mem_store ? 4'd6 : 4'd4) : 4'd0;
    assign exc_addr  = exception ? ex_result : '0;
    assign exc_pc    = exception ? ex_pc : '0;
    assign ex_idle   = !ex_valid || ex_done;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // NOTE: synchronous reset clears every register here, so an abandoned transaction leaves no residue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_store     <= 1'b0;
            r_size      <= 2'd0;
            r_lane      <= 2'd0;
            r_sext      <= 1'b0;
            r_rd        <= 5'd0;
            r_rd_we     <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= 4'd0;
            r_wb_we     <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= '0;
        end else begin
            r_wb_we <= 1'b0;
            if (w_start) begin
                r_store     <= ex_mem_store;
                r_size      <= ex_mem_size;
                r_lane      <= ex_result[1:0];
                r_sext      <= ex_mem_sext;
                r_rd        <= ex_rd;
                r_rd_we     <= ex_rd_we;
                r_bus_req   <= 1'b1;
                r_bus_we    <= ex_mem_store;
                r_bus_addr  <= {ex_result[XLEN-1:2], 2'b00};
                r_bus_wdata <= w_wdata;
                r_bus_be    <= w_be;
            end
            if (w_accept) r_bus_req <= 1'b0;
            if (w_alu) begin
                r_wb_we   <= ex_rd_we;
                r_wb_rd   <= ex_rd;
                r_wb_data <= ex_result;
            end
            if (w_resp) begin
                r_wb_we   <= r_rd_we;
                r_wb_rd   <= r_rd;
                r_wb_data <= w_load;
            end
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;
    assign wb_we     = r_wb_we;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;

endmodule
